sine_voice_scheduler: RTL and testbench

Time-multiplexes one shared synchronous quarter-sine table across VOICES oscillator voices. Once per audio sample, triggered by an lrclk rising edge, it steps every voice through phase mirroring, table lookup and sign restoration, then mixes the voices into one output sample. It sits between the host configuration registers and the I2S transmitter, in place of one table per voice.

---
 rtl/sine_voice_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_sine_voice_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_voice_scheduler.sv
// sine_voice_scheduler
//
// Purpose: shares one synchronous quarter-sine table among VOICES oscillator
// voices. On each lrclk rising edge every voice is stepped through phase
// mirroring, table lookup and sign restoration. The voice values are summed
// and scaled down by VOICES to form one output sample.
//
// Optional feature macro: SINE_VOICE_GATE_EN
//   When defined, the cfg_gate port is present. It is sampled at frame start.
//   A gated-off voice is skipped entirely, adds 0 to the mix, and has its
//   phase held at 0.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   reset      synchronous, active-high reset
//   lrclk      codec word clock (asynchronous); a rising edge starts a frame
//   cfg_we     frequency write strobe
//   cfg_voice  voice targeted by the write
//   cfg_freq   new phase increment
//   cfg_gate   per-voice enable (only with SINE_VOICE_GATE_EN)
//   tbl_addr   registered address to the shared ROM
//   tbl_data   ROM data, valid one clk after tbl_addr changes
//   out        signed mixed sample, held between frames
//   out_valid  one-cycle pulse when out updates
//   busy       high while a frame is in progress
//   overrun    sticky flag: an lrclk edge arrived while busy
module sine_voice_scheduler #(
   parameter int BITSIZE   = 24,
   parameter int PHASESIZE = 16,
   parameter int TABLESIZE = 9,
   parameter int VOICES    = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         lrclk,
   input  logic                         cfg_we,
   input  logic [$clog2(VOICES)-1:0]    cfg_voice,
   input  logic [PHASESIZE-1:0]         cfg_freq,
`ifdef SINE_VOICE_GATE_EN
   input  logic [VOICES-1:0]            cfg_gate,
`endif
   output logic [TABLESIZE-1:0]         tbl_addr,
   input  logic [BITSIZE-1:0]           tbl_data,
   output logic signed [BITSIZE-1:0]    out,
   output logic                         out_valid,
   output logic                         busy,
   output logic                         overrun
);

   localparam int VW = $clog2(VOICES);
   localparam int AW = BITSIZE + VW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_ACC,
      S_OUT
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic [VW-1:0]             r_voice;
   logic [VW-1:0]             w_next_voice;
   logic [2:0]                r_sync;
   logic                      w_edge;
   logic                      r_neg;
   logic signed [AW-1:0]      r_acc;
   logic signed [AW-1:0]      w_data_ext;
   logic [PHASESIZE-1:0]      r_phase [VOICES];
   logic [PHASESIZE-1:0]      r_freq  [VOICES];
   logic [TABLESIZE-1:0]      r_tbl_addr;
   logic [TABLESIZE-1:0]      w_idx;
   logic [TABLESIZE-1:0]      w_addr;
   logic signed [BITSIZE-1:0] r_out;
   logic                      r_out_valid;
   logic                      r_overrun;

`ifdef SINE_VOICE_GATE_EN
   logic [VOICES-1:0]         r_gate;
   logic                      w_first_found;
   logic [VW-1:0]             w_first_idx;
   logic                      w_succ_found;
   logic [VW-1:0]             w_succ_idx;
`endif

   // r_sync[1:0] form the synchronizer. r_sync[2] is the delayed copy used
   // for edge detection.
   assign w_edge = r_sync[1] & ~r_sync[2];

   // Quarter-wave mirroring. The second quadrant bit reverses the index.
   assign w_idx  = r_phase[r_voice][PHASESIZE-3 -: TABLESIZE];
   assign w_addr = r_phase[r_voice][PHASESIZE-2] ? ~w_idx : w_idx;

   assign w_data_ext = {{VW{tbl_data[BITSIZE-1]}}, tbl_data};

`ifdef SINE_VOICE_GATE_EN
   // Lowest enabled voice (for frame start), and the next enabled voice
   // after the current one (for the ACC exit).
   always_comb begin
      w_first_found = 1'b0;
      w_first_idx   = '0;
      w_succ_found  = 1'b0;
      w_succ_idx    = '0;
      for (int i = VOICES - 1; i >= 0; i--) begin
         if (cfg_gate[i]) begin
            w_first_found = 1'b1;
            w_first_idx   = VW'(i);
         end
         if (r_gate[i] && (i > int'(r_voice))) begin
            w_succ_found = 1'b1;
            w_succ_idx   = VW'(i);
         end
      end
   end
`endif

   always_comb begin
      w_next_state = r_state;
      w_next_voice = r_voice;
      case (r_state)
         S_IDLE: begin
            if (w_edge) begin
`ifdef SINE_VOICE_GATE_EN
               if (w_first_found) begin
                  w_next_state = S_ADDR;
                  w_next_voice = w_first_idx;
               end else begin
                  w_next_state = S_OUT;
               end
`else
               w_next_state = S_ADDR;
               w_next_voice = '0;
`endif
            end
         end
         S_ADDR: w_next_state = S_WAIT;
         S_WAIT: w_next_state = S_ACC;
         S_ACC: begin
`ifdef SINE_VOICE_GATE_EN
            if (w_succ_found) begin
               w_next_state = S_ADDR;
               w_next_voice = w_succ_idx;
            end else begin
               w_next_state = S_OUT;
            end
`else
            if (r_voice == VW'(VOICES - 1)) begin
               w_next_state = S_OUT;
            end else begin
               w_next_state = S_ADDR;
               w_next_voice = r_voice + VW'(1);
            end
`endif
         end
         S_OUT:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_voice     <= '0;
         r_sync      <= '0;
         r_neg       <= 1'b0;
         r_acc       <= '0;
         r_tbl_addr  <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
         for (int v = 0; v < VOICES; v++) begin
            r_phase[v] <= '0;
            r_freq[v]  <= '0;
         end
`ifdef SINE_VOICE_GATE_EN
         r_gate      <= '0;
`endif
      end else begin
         r_sync      <= {r_sync[1:0], lrclk};
         r_state     <= w_next_state;
         r_voice     <= w_next_voice;
         r_out_valid <= (r_state == S_OUT);

         // Any edge outside IDLE is dropped, including one during OUT.
         if (w_edge && (r_state != S_IDLE))
            r_overrun <= 1'b1;

         // A write that coincides with this voice's ACC takes effect after the
         // increment, because the increment reads the registered old value.
         if (cfg_we)
            r_freq[cfg_voice] <= cfg_freq;

         case (r_state)
            S_IDLE: begin
               if (w_edge) begin
                  r_acc <= '0;
`ifdef SINE_VOICE_GATE_EN
                  r_gate <= cfg_gate;
                  for (int v = 0; v < VOICES; v++)
                     if (!cfg_gate[v])
                        r_phase[v] <= '0;
`endif
               end
            end
            S_ADDR: begin
               r_tbl_addr <= w_addr;
               r_neg      <= r_phase[r_voice][PHASESIZE-1];
            end
            S_ACC: begin
               r_acc            <= r_acc + (r_neg ? -w_data_ext : w_data_ext);
               r_phase[r_voice] <= r_phase[r_voice] + r_freq[r_voice];
            end
            S_OUT: begin
               // Taking the top BITSIZE bits of acc is the same as an
               // arithmetic shift right by log2(VOICES).
               r_out <= r_acc[AW-1:VW];
            end
            default: ;
         endcase
      end
   end

   assign tbl_addr  = r_tbl_addr;
   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign busy      = (r_state != S_IDLE);
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Testbench for sine_voice_scheduler.
//
// The bench keeps its own model of the voices (phase and frequency arrays)
// and of the quarter-sine table. For every frame it launches, it pushes the
// expected table addresses and the expected mixed sample into queues. A
// negedge monitor pops those queues as the DUT presents addresses and
// out_valid pulses.
module tb_sine_voice_scheduler;

   localparam int VOICES = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        lrclk;
   logic        cfg_we;
   logic [1:0]  cfg_voice;
   logic [15:0] cfg_freq;
   logic [8:0]  tbl_addr;
   logic [23:0] tbl_data;
   logic [23:0] out;
   logic        out_valid;
   logic        busy;
   logic        overrun;
`ifdef SINE_VOICE_GATE_EN
   logic [VOICES-1:0] cfg_gate = '1;
`endif

   sine_voice_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .lrclk     (lrclk),
      .cfg_we    (cfg_we),
      .cfg_voice (cfg_voice),
      .cfg_freq  (cfg_freq),
`ifdef SINE_VOICE_GATE_EN
      .cfg_gate  (cfg_gate),
`endif
      .tbl_addr  (tbl_addr),
      .tbl_data  (tbl_data),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Synchronous ROM model: data follows the address by one clock.
   logic [23:0] rom [512];
   always @(posedge clk) tbl_data <= rom[tbl_addr];

   int m_phase [VOICES];
   int m_freq  [VOICES];
   int          addr_q[$];
   logic [23:0] out_q[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame: read each voice's value from the quarter table by
   // quadrant, sum the values, then divide by the voice count (floor).
   task automatic model_frame();
      int sum = 0;
      int s4;
      logic [31:0] s4b;
      for (int v = 0; v < VOICES; v++) begin
         int p    = m_phase[v];
         int quad = p / 16384;
         int idx  = (p / 32) % 512;
         int a    = (quad % 2 == 1) ? 511 - idx : idx;
         int val  = int'(rom[a]);
         sum += (quad >= 2) ? -val : val;
         addr_q.push_back(a);
         m_phase[v] = (p + m_freq[v]) % 65536;
      end
      s4  = sum >>> 2;
      s4b = s4;
      out_q.push_back(s4b[23:0]);
   endtask

   task automatic model_reset();
      for (int v = 0; v < VOICES; v++) begin
         m_phase[v] = 0;
         m_freq[v]  = 0;
      end
   endtask

   // Monitor: k counts clocks since busy rose. Voice v's address is
   // presented in the WAIT cycle at k = 3v+1, and out_valid arrives at
   // k = 3*VOICES+1.
   int  mon_k = -1;
   logic mon_prev_busy = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         mon_k = -1;
         mon_prev_busy = 1'b0;
      end else begin
         if (busy && !mon_prev_busy) mon_k = 0;
         else if (mon_k >= 0) mon_k++;
         if (busy && (mon_k % 3 == 1) && (mon_k < 3 * VOICES)) begin
            if (addr_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL tbl_addr_unexpected: got 0x%0h with no frame expected", tbl_addr);
            end else begin
               check("tbl_addr", 32'(tbl_addr), 32'(addr_q.pop_front()));
            end
         end
         if (out_valid) begin
            check("out_latency", 32'(mon_k), 32'(3 * VOICES + 1));
            if (out_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL out_unexpected: got 0x%0h with no frame expected", out);
            end else begin
               check("out", 32'(out), 32'(out_q.pop_front()));
            end
         end
         mon_prev_busy = busy;
      end
   end

   task automatic cfg_write(input int v, input int f);
      cfg_we    = 1'b1;
      cfg_voice = v[1:0];
      cfg_freq  = f[15:0];
      @(posedge clk); #1;
      cfg_we    = 1'b0;
      m_freq[v] = f;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         n_vec++; n_err++;
         $display("FAIL busy_timeout: busy=%b after %0d clk, expected 0", busy, n);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_frame();
      model_frame();
      lrclk = 1'b1;
      repeat (8) @(posedge clk);
      #1 lrclk = 1'b0;
      wait_idle();
   endtask

   // Launch a frame and write voice v's frequency exactly in its ACC cycle.
   task automatic run_frame_midwrite(input int v, input int f);
      int n = 0;
      model_frame();
      lrclk = 1'b1;
      while (busy !== 1'b1 && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 12) begin
         n_vec++; n_err++;
         $display("FAIL start_timeout: busy=%b after %0d clk, expected 1", busy, n);
      end
      repeat (3 * v + 2) @(posedge clk);
      #1;
      cfg_we    = 1'b1;
      cfg_voice = v[1:0];
      cfg_freq  = f[15:0];
      @(posedge clk); #1;
      cfg_we = 1'b0;
      lrclk  = 1'b0;
      m_freq[v] = f;
      wait_idle();
   endtask

   initial begin
      reset     = 1'b1;
      lrclk     = 1'b0;
      cfg_we    = 1'b0;
      cfg_voice = '0;
      cfg_freq  = '0;
      for (int i = 0; i < 512; i++) rom[i] = 24'(i * 16);
      model_reset();

      // Reset with lrclk toggling: nothing may start.
      repeat (4) begin
         @(posedge clk); #1;
         lrclk = ~lrclk;
      end
      lrclk = 1'b0;
      @(posedge clk); #1;
      check("rst_out",       32'(out),       32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      check("rst_overrun",   32'(overrun),   32'h0);
      check("rst_tbl_addr",  32'(tbl_addr),  32'h0);
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 32'h0);

      // Table read and mix: all voices read entry 0.
      rom[0] = 24'h000400;
      run_frame();

      // Quadrant walk on voice 0.
      rom[0]   = 24'h000100;
      rom[511] = 24'h7FFFFF;
      cfg_write(0, 16'h4000);
      repeat (4) run_frame();

      // Mid-frame write to voice 1 during its ACC cycle.
      cfg_write(0, 0);
      run_frame_midwrite(1, 16'h0100);
      run_frame();
      run_frame();

      // Overrun: a second edge 6 clk after the first.
      check("pre_overrun", 32'(overrun), 32'h0);
      model_frame();
      lrclk = 1'b1;
      repeat (3) @(posedge clk);
      #1 lrclk = 1'b0;
      repeat (3) @(posedge clk);
      #1 lrclk = 1'b1;
      repeat (3) @(posedge clk);
      #1 lrclk = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      wait_idle();
      check("overrun_set", 32'(overrun), 32'h1);
      run_frame();
      check("overrun_sticky", 32'(overrun), 32'h1);

      // Randomized frames with random table contents and frequencies.
      for (int i = 0; i < 512; i++) rom[i] = 24'($urandom_range(0, 24'h7FFFFF));
      for (int f = 0; f < 24; f++) begin
         if ($urandom_range(0, 1) == 1)
            cfg_write(int'($urandom_range(0, VOICES - 1)), int'($urandom_range(0, 16'hFFFF)));
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
         run_frame();
      end

      check("pending_addr", 32'(addr_q.size()), 32'h0);
      check("pending_out",  32'(out_q.size()),  32'h0);

      // Final reset clears the sticky flag and the held sample.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check("final_overrun", 32'(overrun), 32'h0);
      check("final_out",     32'(out),     32'h0);
      rom[0] = 24'h000400;
      run_frame();
      check("final_pending", 32'(out_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
